// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared opcode constants for the five-stage MIPS core front end.
//   Holds the primary opcode values (instr[31:26]) used to classify
//   instructions and the canonical bubble word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // All-zero word: sll $0,$0,0, i.e. a no-op that also decodes as a bubble.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/mips_op_class.sv
// mips_op_class
//   Purely combinational opcode classifier.
//   Ports:
//     op           in  6 : primary opcode instr[31:26]
//     imm_unsigned out 1 : immediate is zero-extended (logical immediates, lui)
//     is_load      out 1 : instruction reads memory into rt
//     uses_rs      out 1 : instruction reads register rs
//     uses_rt      out 1 : instruction reads register rt
module mips_op_class
  import mips_pkg::*;
(
  input  logic [5:0] op,
  output logic       imm_unsigned,
  output logic       is_load,
  output logic       uses_rs,
  output logic       uses_rt
);

  always_comb begin
    imm_unsigned = 1'b0;
    is_load      = 1'b0;
    uses_rs      = 1'b1;
    uses_rt      = 1'b0;

    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_unsigned = 1'b1;
      // lui has no rs field in use.
      OP_LUI: begin
        imm_unsigned = 1'b1;
        uses_rs      = 1'b0;
      end
      OP_J, OP_JAL: uses_rs = 1'b0;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      // rt is a source for R-type, branch compares and store data.
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: uses_rt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// if_id_stage
//   IF/ID pipeline register with immediate decode and load-use hazard
//   detection. Holds the fetched instruction for decode, exposes the
//   16-bit immediate and its zero/sign-extend select for the extender,
//   and tracks the instruction that just entered EX so that a load
//   followed by a dependent instruction costs exactly one bubble.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     instr_in        : fetched instruction (32)
//     pc_plus4_in     : PC+4 of the fetched instruction (32)
//     in_valid        : fetch word valid
//     stall           : freeze from later stages
//     flush           : taken branch/jump, discard IF/ID contents
//     in_ready        : fetch may advance (low = hold PC)
//     instr_out       : held instruction, zero when bubble (32)
//     pc_plus4_out    : held PC+4 (32)
//     out_valid       : held instruction is real
//     imm_half        : instr_out[15:0] for the extender
//     imm_unsigned    : extender zero-extend select
//     rs, rt, rd      : register fields of the held instruction
//     hazard_stall    : load-use bubble request
module if_id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_plus4_out,
  output logic        out_valid,
  output logic [15:0] imm_half,
  output logic        imm_unsigned,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        hazard_stall
);

  logic [31:0] instr_p1;
  logic [31:0] pc_plus4_p1;
  logic        vld_p1;

  logic        ex_is_load;
  logic [4:0]  ex_rt;

  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        unused_id_is_load;

  logic [5:0]  shadow_op;
  logic        shadow_is_load;
  logic        unused_shadow_imm;
  logic        unused_shadow_rs;
  logic        unused_shadow_rt;

  logic        hold;

  // ID stage: decode of the held instruction
  assign instr_out    = instr_p1;
  assign pc_plus4_out = pc_plus4_p1;
  assign out_valid    = vld_p1;
  assign rs           = instr_p1[25:21];
  assign rt           = instr_p1[20:16];
  assign rd           = instr_p1[15:11];
  assign imm_half     = instr_p1[15:0];

  mips_op_class u_id_class (
    .op           (instr_p1[31:26]),
    .imm_unsigned (imm_unsigned),
    .is_load      (unused_id_is_load),
    .uses_rs      (id_uses_rs),
    .uses_rt      (id_uses_rt)
  );

  assign hazard_stall = vld_p1 & ex_is_load & (ex_rt != 5'd0) &
                        ((id_uses_rs & (rs == ex_rt)) |
                         (id_uses_rt & (rt == ex_rt)));

  assign hold     = stall | hazard_stall;
  assign in_ready = ~hold;

  // What moves into EX on the next unstalled edge: a bubble during a
  // hazard or when ID holds nothing, otherwise the ID instruction.
  assign shadow_op = (hazard_stall | ~vld_p1) ? OP_RTYPE : instr_p1[31:26];

  mips_op_class u_shadow_class (
    .op           (shadow_op),
    .imm_unsigned (unused_shadow_imm),
    .is_load      (shadow_is_load),
    .uses_rs      (unused_shadow_rs),
    .uses_rt      (unused_shadow_rt)
  );

  // IF -> ID register and ID -> EX shadow
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_p1    <= NOP_WORD;
      pc_plus4_p1 <= 32'h0;
      vld_p1      <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_rt       <= 5'd0;
    end else begin
      // Flush wins over hold so a taken branch always squashes ID.
      if (flush) begin
        instr_p1 <= NOP_WORD;
        vld_p1   <= 1'b0;
      end else if (!hold) begin
        instr_p1    <= in_valid ? instr_in : NOP_WORD;
        pc_plus4_p1 <= pc_plus4_in;
        vld_p1      <= in_valid;
      end

      // The shadow follows the EX stage, which only freezes on stall.
      if (!stall) begin
        ex_is_load <= shadow_is_load;
        ex_rt      <= (hazard_stall | ~vld_p1) ? 5'd0 : rt;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] instr_in;
  logic [31:0] pc_plus4_in;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic        in_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4_out;
  logic        out_valid;
  logic [15:0] imm_half;
  logic        imm_unsigned;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        hazard_stall;

  if_id_stage dut (
    .clk          (clk),
    .reset        (reset),
    .instr_in     (instr_in),
    .pc_plus4_in  (pc_plus4_in),
    .in_valid     (in_valid),
    .stall        (stall),
    .flush        (flush),
    .in_ready     (in_ready),
    .instr_out    (instr_out),
    .pc_plus4_out (pc_plus4_out),
    .out_valid    (out_valid),
    .imm_half     (imm_half),
    .imm_unsigned (imm_unsigned),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .hazard_stall (hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        vld;
    logic        haz;
    logic        uns;
    logic [31:0] ext;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: what sits in ID, and what sits in EX.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_vld;
  logic        m_ex_valid;   // a real instruction (not a bubble) is in EX
  logic [31:0] m_ex_instr;

  function automatic bit op_is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit op_unsigned(input logic [5:0] op);
    return op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F};
  endfunction

  function automatic bit op_reads_rs(input logic [5:0] op);
    return !(op inside {6'h02, 6'h03, 6'h0F});
  endfunction

  function automatic bit op_reads_rt(input logic [5:0] op);
    return op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
  endfunction

  // Load-use: the EX instruction is a real load writing a non-zero
  // register that the ID instruction reads.
  function automatic bit model_hazard();
    logic [4:0] dst;
    logic [4:0] s;
    logic [4:0] t;
    dst = m_ex_instr[20:16];
    s   = m_instr[25:21];
    t   = m_instr[20:16];
    if (!m_vld || !m_ex_valid) return 1'b0;
    if (!op_is_load(m_ex_instr[31:26]) || dst == 5'd0) return 1'b0;
    return (op_reads_rs(m_instr[31:26]) && s == dst) ||
           (op_reads_rt(m_instr[31:26]) && t == dst);
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] ins);
    if (op_unsigned(ins[31:26])) return {16'h0000, ins[15:0]};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model steps across the same edge and the
  // resulting expectation is queued for the monitor.
  task automatic step(input logic [31:0] ins, input logic v, input logic st,
                      input logic fl, input logic rst);
    bit   haz;
    exp_t e;
    instr_in    = ins;
    pc_plus4_in = $urandom;
    in_valid    = v;
    stall       = st;
    flush       = fl;
    reset       = rst;
    haz = model_hazard();
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_vld = 1'b0;
      m_ex_valid = 1'b0; m_ex_instr = 32'h0;
    end else begin
      if (!st) begin
        m_ex_valid = m_vld && !haz;
        m_ex_instr = (m_vld && !haz) ? m_instr : 32'h0;
      end
      if (fl) begin
        m_instr = 32'h0; m_vld = 1'b0;
      end else if (!(st || haz)) begin
        m_instr = v ? ins : 32'h0;
        m_pc    = pc_plus4_in;
        m_vld   = v;
      end
    end
    @(posedge clk);
    e.instr = m_instr;
    e.pc    = m_pc;
    e.vld   = m_vld;
    e.haz   = model_hazard();
    e.uns   = op_unsigned(m_instr[31:26]);
    e.ext   = extend(m_instr);
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compares everything the DUT presents after each edge.
  initial begin
    exp_t e;
    logic [31:0] dut_ext;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        dut_ext = imm_unsigned ? {16'h0000, imm_half} : {{16{imm_half[15]}}, imm_half};
        check("instr_out", instr_out, e.instr);
        check("pc_plus4_out", pc_plus4_out, e.pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, e.vld});
        check("hazard_stall", {31'b0, hazard_stall}, {31'b0, e.haz});
        check("in_ready", {31'b0, in_ready}, {31'b0, !(stall || e.haz)});
        check("imm_half", {16'h0, imm_half}, {16'h0, e.instr[15:0]});
        check("imm_unsigned", {31'b0, imm_unsigned}, {31'b0, e.uns});
        check("rs", {27'b0, rs}, {27'b0, e.instr[25:21]});
        check("rt", {27'b0, rt}, {27'b0, e.instr[20:16]});
        check("rd", {27'b0, rd}, {27'b0, e.instr[15:11]});
        check("extended_imm", dut_ext, e.ext);
      end
    end
  end

  logic [5:0] op_pool [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
                                6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = op_pool[$urandom_range(0, 17)];
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  initial begin
    int wait_cycles;
    m_instr = 32'h0; m_pc = 32'h0; m_vld = 1'b0;
    m_ex_valid = 1'b0; m_ex_instr = 32'h0;
    instr_in = 32'h0; pc_plus4_in = 32'h0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; reset = 1'b1;

    // Reset, then ori and addi immediates.
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h3421FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h2021FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // lw $t0 then add using $t0: one bubble.
    step(32'h8C080000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h01094820, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // lw $zero then add: no hazard.
    step(32'h8C000000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00004820, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Hazard cycle with flush.
    step(32'h8C080000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h01094820, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stall three cycles during a hazard.
    step(32'h8C080000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h01094820, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while stalled with a valid lw held.
    step(32'h8C080000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1);
    step(32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(rand_instr(),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 2),
           ($urandom_range(0, 9) < 1),
           ($urandom_range(0, 99) < 3));
    end
    stall = 1'b0; flush = 1'b0; reset = 1'b0;

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register with immediate-field decode and load-use hazard detection for the five-stage MIPS core. It captures each fetched instruction, holds it for the decode stage, and presents the 16-bit immediate plus the zero/sign-extend select that drive the sign-extension unit directly downstream. It tracks the instruction that has just moved into EX so it can insert exactly one bubble on a load-use dependency. It also honours external stall and branch flush.

## Interface
- No parameters; all widths fixed (32-bit instruction/PC, 5-bit register indices).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_in` in 32: fetched instruction word.
- `pc_plus4_in` in 32: PC+4 of the fetched instruction.
- `in_valid` in 1: fetch word valid this cycle.
- `stall` in 1: external freeze from later stages.
- `flush` in 1: taken branch/jump; discard the IF/ID contents.
- `in_ready` out 1: `!(stall | hazard_stall)`; fetch must hold its PC when low.
- `instr_out` out 32: held instruction, 0x00000000 when bubble.
- `pc_plus4_out` out 32: held PC+4.
- `out_valid` out 1: held instruction is real.
- `imm_half` out 16: `instr_out[15:0]`, feeds the extender HalfWord input.
- `imm_unsigned` out 1: feeds the extender Unsigned input.
- `rs`, `rt`, `rd` out 5 each; `hazard_stall` out 1.

## Operation
- Register priority each edge: reset > flush > hold (`stall | hazard_stall`) > load.
- Load: `instr_out <= instr_in`, `pc_plus4_out <= pc_plus4_in`, `out_valid <= in_valid`. If `in_valid=0`, `instr_out <= 0`.
- Flush: `instr_out <= 0`, `out_valid <= 0`, `pc_plus4_out` unchanged. Flush overrides hold.
- Hold: all IF/ID registers keep their value.
- Immediate class from `op = instr_out[31:26]`:
  - `imm_unsigned=1` for andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F.
  - `imm_unsigned=0` for every other opcode, including bubbles.
- EX shadow registers: `ex_is_load` and `ex_rt[4:0]`.
  - Advance when `stall=0`. If `hazard_stall=1`, they load a bubble (`ex_is_load=0`). Otherwise they load the ID instruction's values, gated by `out_valid`.
  - Hold when `stall=1`.
- Loads are lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
- Source usage:
  - uses_rs: every op except j 0x02, jal 0x03, lui 0x0F.
  - uses_rt: R-type 0x00, beq 0x04, bne 0x05, sb 0x28, sh 0x29, sw 0x2B.
- `hazard_stall = out_valid & ex_is_load & (ex_rt != 0) & ((uses_rs & rs == ex_rt) | (uses_rt & rt == ex_rt))`.

## Timing
- Latency: `instr_in` appears on `instr_out` one cycle after the edge that loads it.
- `imm_half`, `imm_unsigned`, `rs`, `rt`, `rd` and `hazard_stall` are combinational from registered state, valid the same cycle as `instr_out`.
- Reset values: `instr_out=0`, `pc_plus4_out=0`, `out_valid=0`, `ex_is_load=0`, `ex_rt=0`. Consequently `hazard_stall=0`, `imm_unsigned=0`, `in_ready=1` while `stall=0`.
- Load-use costs exactly one cycle: the bubble enters the shadow, so `hazard_stall` drops on the next edge.
- Exception: if `stall` is also high, the shadow freezes and the hazard persists until `stall` falls.
- Flush during a hazard: IF/ID is bubbled; the hazard clears on that edge.
- Reset mid-stall or mid-hazard: all state returns to reset values on the edge; nothing is retained.
- `$zero` destination (`ex_rt=0`) never raises a hazard.

## Structure
- Shared package `mips_pkg`: opcode localparams (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, the five load and three store opcodes) and `NOP_WORD = 32'h0`.
- One combinational sub-module, `mips_op_class`: maps opcode to `imm_unsigned`, `is_load`, `uses_rs`, `uses_rt`. It is instantiated twice: once on the ID instruction, once for the shadow capture.

## Test plan
- Reset with `stall=0`, then load ori `0x3421FFFF` with `in_valid=1` → next cycle `out_valid=1`, `imm_half=FFFF`, `imm_unsigned=1`; the downstream extender produces `0000FFFF`.
- Load addi `0x2021FFFF` → `imm_unsigned=0`; the downstream extender produces `FFFFFFFF`.
- lw `$t0` (`0x8C080000`) followed by add using `$t0` as rs (`0x01094820`) → `hazard_stall=1` and `in_ready=0` for exactly one cycle, add held; the next cycle `hazard_stall=0`.
- Same pair with lw targeting `$zero` (`0x8C000000`), add `0x00004820` → no hazard.
- Hazard cycle with `flush=1` → `instr_out=0`, `out_valid=0`, `hazard_stall=0` next cycle. Separately, `stall=1` for 3 cycles during a hazard → `instr_out` stable and `hazard_stall=1` throughout; it clears one cycle after `stall` falls.
- Assert `reset` while `stall=1` and a valid lw is held → all outputs return to reset values on the next edge.
